// File: rtl/digit_chain_counter.sv
// Multi-digit up/down modulo counter with clamped parallel load and a registered wrap pulse.
// Define SATURATE_EN to make down counting stop at zero and raise a registered done flag.
module digit_chain_counter #(
  parameter int NDIG    = 2,
  parameter int W       = 4,
  parameter int BASE    = 10,
  parameter int TOP_MOD = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              ctrl,
  input  logic              set,
  input  logic [NDIG*W-1:0] outsource,
  output logic [NDIG*W-1:0] count,
  output logic              carry,
  output logic              zero,
  output logic              done
);

  // Only the most-significant digit uses TOP_MOD; W+1 bits holds a modulus of 2^W.
  function automatic logic [W:0] digit_mod(input int idx);
    return (idx == NDIG - 1) ? (W+1)'(TOP_MOD) : (W+1)'(BASE);
  endfunction

  logic [NDIG*W-1:0] count_q, count_d;
  logic [NDIG*W-1:0] up_next, dn_next, load_val;
  logic              carry_q, carry_d;
  logic              at_max, at_zero;
  logic              ripple_up, ripple_dn;
  logic [W:0]        cur, md, ld;

  always_comb begin
    up_next   = count_q;
    dn_next   = count_q;
    load_val  = '0;
    at_max    = 1'b1;
    at_zero   = 1'b1;
    ripple_up = 1'b1;
    ripple_dn = 1'b1;
    cur       = '0;
    md        = '0;
    ld        = '0;
    for (int i = 0; i < NDIG; i++) begin
      cur = {1'b0, count_q[i*W +: W]};
      md  = digit_mod(i);
      ld  = {1'b0, outsource[i*W +: W]};
      if (ld >= md) begin
        ld = md - 1'b1;
      end
      load_val[i*W +: W] = ld[W-1:0];

      // A digit steps only when every lower digit is at its rollover value.
      if (ripple_up) begin
        up_next[i*W +: W] = (cur == md - 1'b1) ? '0 : W'(cur + 1'b1);
      end
      if (ripple_dn) begin
        dn_next[i*W +: W] = (cur == '0) ? W'(md - 1'b1) : W'(cur - 1'b1);
      end
      ripple_up = ripple_up && (cur == md - 1'b1);
      ripple_dn = ripple_dn && (cur == '0);

      if (cur != md - 1'b1) begin
        at_max = 1'b0;
      end
      if (cur != '0) begin
        at_zero = 1'b0;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    carry_d = 1'b0;
    if (set) begin
      count_d = load_val;
    end else if (tick && !ctrl) begin
      count_d = up_next;
      carry_d = at_max;
    end else if (tick && ctrl) begin
`ifdef SATURATE_EN
      if (!at_zero) begin
        count_d = dn_next;
      end
`else
      count_d = dn_next;
      carry_d = at_zero;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      carry_q <= 1'b0;
    end else begin
      count_q <= count_d;
      carry_q <= carry_d;
    end
  end

`ifdef SATURATE_EN
  logic done_q, done_d;

  // done marks arrival at zero by counting down; a hold at zero keeps its previous state.
  always_comb begin
    done_d = done_q;
    if (set) begin
      done_d = 1'b0;
    end else if (tick && !ctrl) begin
      done_d = 1'b0;
    end else if (tick && ctrl && !at_zero && (dn_next == '0)) begin
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
    end
  end

  assign done = done_q;
`else
  assign done = 1'b0;
`endif

  assign count = count_q;
  assign carry = carry_q;
  assign zero  = (count_q == '0);

endmodule

// File: tb/tb_digit_chain_counter.sv
// Self-checking bench for digit_chain_counter with NDIG=2, BASE=10, TOP_MOD=6.
// Table vectors go through a scoreboard queue; async reset and saturation are hand-written sequences.
module tb_digit_chain_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       ctrl;
  logic       set;
  logic [7:0] outsource;
  logic [7:0] count;
  logic       carry;
  logic       zero;
  logic       done;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    string      name;
    logic       set;
    logic       tick;
    logic       ctrl;
    logic [7:0] outsource;
    logic [7:0] exp_count;
    logic       exp_carry;
    logic       exp_zero;
    logic       exp_done;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  digit_chain_counter #(
    .NDIG(2), .W(4), .BASE(10), .TOP_MOD(6)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .ctrl(ctrl), .set(set),
    .outsource(outsource), .count(count), .carry(carry), .zero(zero), .done(done)
  );

  always #5 clk = ~clk;

  // Watchdog so a broken DUT or bench can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, actual=expired required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  function automatic void add(input string name, input logic s, input logic t, input logic c,
                              input logic [7:0] os, input logic [7:0] ec, input logic ecar,
                              input logic ed);
    vec_t v;
    v.name      = name;
    v.set       = s;
    v.tick      = t;
    v.ctrl      = c;
    v.outsource = os;
    v.exp_count = ec;
    v.exp_carry = ecar;
    v.exp_zero  = (ec == 8'h00);
    v.exp_done  = ed;
    vecs.push_back(v);
  endfunction

  task automatic check_output(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic check_all(input string name, input logic [7:0] ec, input logic ecar,
                           input logic ez, input logic ed);
    check_output({name, ".count"}, count, ec);
    check_output({name, ".carry"}, {7'd0, carry}, {7'd0, ecar});
    check_output({name, ".zero"},  {7'd0, zero},  {7'd0, ez});
    check_output({name, ".done"},  {7'd0, done},  {7'd0, ed});
  endtask

  task automatic apply_stimulus(input vec_t v);
    vec_t e;
    @(negedge clk);
    set       = v.set;
    tick      = v.tick;
    ctrl      = v.ctrl;
    outsource = v.outsource;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_all(e.name, e.exp_count, e.exp_carry, e.exp_zero, e.exp_done);
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; ctrl = 1'b0; set = 1'b0; outsource = 8'h00;

    // Up wrap through terminal count, then back-to-back wraps
    add("load58",    1, 0, 0, 8'h58, 8'h58, 0, 0);
    add("up59",      0, 1, 0, 8'h00, 8'h59, 0, 0);
    add("up_wrap",   0, 1, 0, 8'h00, 8'h00, 1, 0);
    add("idle",      0, 0, 0, 8'h00, 8'h00, 0, 0);
    add("load58b",   1, 0, 0, 8'h58, 8'h58, 0, 0);
    add("up59b",     0, 1, 0, 8'h00, 8'h59, 0, 0);
    add("up_wrap_b", 0, 1, 0, 8'h00, 8'h00, 1, 0);
    add("up01",      0, 1, 0, 8'h00, 8'h01, 0, 0);
    // Clamped loads and set-over-tick priority
    add("clamp7C",   1, 0, 0, 8'h7C, 8'h59, 0, 0);
    add("clampA3",   1, 0, 0, 8'hA3, 8'h53, 0, 0);
    add("clamp2F",   1, 0, 0, 8'h2F, 8'h29, 0, 0);
    add("load12",    1, 0, 0, 8'h12, 8'h12, 0, 0);
    add("set_tick",  1, 1, 0, 8'h33, 8'h33, 0, 0);
    add("up_ripple", 1, 0, 0, 8'h19, 8'h19, 0, 0);
    add("up20",      0, 1, 0, 8'h00, 8'h20, 0, 0);
    add("dn19",      0, 1, 1, 8'h00, 8'h19, 0, 0);
`ifndef SATURATE_EN
    add("load00",    1, 0, 0, 8'h00, 8'h00, 0, 0);
    add("dn_wrap",   0, 1, 1, 8'h00, 8'h59, 1, 0);
    for (int k = 1; k <= 10; k++) begin
      add($sformatf("dn_%0d", k), 0, 1, 1, 8'h00, bcd(59 - k), 0, 0);
    end
    add("load00c",   1, 0, 0, 8'h00, 8'h00, 0, 0);
    add("dir_up01",  0, 1, 0, 8'h00, 8'h01, 0, 0);
    add("dir_dn00",  0, 1, 1, 8'h00, 8'h00, 0, 0);
    add("dir_wrap",  0, 1, 1, 8'h00, 8'h59, 1, 0);
    add("dir_upw",   0, 1, 0, 8'h00, 8'h00, 1, 0);
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_all("reset", 8'h00, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i]);
    end

    // Free-run up from zero, then async reset between edges at count 27
    @(negedge clk);
    set = 1'b1; tick = 1'b0; ctrl = 1'b0; outsource = 8'h00;
    @(negedge clk);
    set = 1'b0; tick = 1'b1;
    for (int n = 1; n <= 27; n++) begin
      @(posedge clk);
      #1;
      if (n % 9 == 0 || n == 27) begin
        check_output($sformatf("run_%0d", n), count, bcd(n));
      end
    end
    #2;
    reset = 1'b1;
    #1;
    check_all("async_rst", 8'h00, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_all("resume01", 8'h01, 1'b0, 1'b0, 1'b0);

`ifdef SATURATE_EN
    // Down to zero, hold there without carry, then an up tick clears done
    @(negedge clk);
    set = 1'b1; tick = 1'b0; outsource = 8'h02;
    @(posedge clk); #1;
    check_all("sat_load02", 8'h02, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    set = 1'b0; tick = 1'b1; ctrl = 1'b1;
    @(posedge clk); #1;
    check_all("sat_dn01", 8'h01, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_all("sat_dn00", 8'h00, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    check_all("sat_hold", 8'h00, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    ctrl = 1'b0;
    @(posedge clk); #1;
    check_all("sat_up01", 8'h01, 1'b0, 1'b0, 1'b0);
`endif

    @(negedge clk);
    tick = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL scoreboard_drain: actual=%0d required=0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
